// File: rtl/d7s_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
package d7s_pkg;

    // Scan controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } d7s_state_e;

    // Hex to 7-segment code, bit0 = segment a, active-high.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/d7s_scan_ctrl_dec.sv
// Combinational hex nibble to 7-segment decoder with an enable.
module d7s_scan_ctrl_dec
    import d7s_pkg::*;
(
    input  logic       en,
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup when enabled, all segments dark otherwise.
    always_comb begin
        if (en) begin
            seg = hex_to_seg(nibble);
        end else begin
            seg = 7'd0;
        end
    end

endmodule

// File: rtl/d7s_scan_ctrl.sv
// Multiplexed 7-segment display scanner with a double-buffered display value.
// Outputs are registered from next-state values so an/seg/frame_done line up
// exactly with the state they describe.
module d7s_scan_ctrl
    import d7s_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int DWELL  = 1000,
    parameter int BLANK  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  wr_valid,
    input  logic [4*DIGITS-1:0]   wr_data,
    output logic                  wr_ready,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW   = $clog2(MAXC + 1);

    d7s_state_e          state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [4*DIGITS-1:0] active_q, active_d;
    logic [4*DIGITS-1:0] shadow_q, shadow_d;
    logic                pending_q, pending_d;
    logic                en_q;
    logic [6:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                frame_done_q, frame_done_d;
    logic                wr_acc_s;
    logic [3:0]          nib_s;
    logic [6:0]          dec_s;

    // Next-state logic: scan sequencing, frame-boundary transfer and write handshake.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        wr_acc_s  = wr_valid && !pending_q;
        case (state_q)
            IDLE: begin
                idx_d = '0;
                cnt_d = '0;
                // Idle is never mid-frame, so a pending value moves straight across.
                if (pending_q) begin
                    active_d  = shadow_q;
                    pending_d = 1'b0;
                end else begin
                    active_d = active_q;
                end
                // en must be seen high on two consecutive edges before scanning.
                if (en && en_q) begin
                    state_d = DRIVE;
                end else begin
                    state_d = IDLE;
                end
            end
            DRIVE: begin
                if (!en) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(DWELL - 1)) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            GAP: begin
                if (!en) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(BLANK - 1)) begin
                    state_d = DRIVE;
                    cnt_d   = '0;
                    if (idx_q == IW'(DIGITS - 1)) begin
                        // Frame boundary: only a value pending before this edge transfers.
                        idx_d = '0;
                        if (pending_q) begin
                            active_d  = shadow_q;
                            pending_d = 1'b0;
                        end else begin
                            active_d = active_q;
                        end
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase
        if (wr_acc_s) begin
            shadow_d  = wr_data;
            pending_d = 1'b1;
        end else begin
            shadow_d = shadow_d;
        end
    end

    // Nibble mux selecting the digit that will be driven after this edge.
    always_comb begin
        nib_s = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            nib_s = (idx_d == IW'(i)) ? active_d[i*4 +: 4] : nib_s;
        end
    end

    d7s_scan_ctrl_dec u_dec (
        .en     (1'b1),
        .nibble (nib_s),
        .seg    (dec_s)
    );

    // Output drive values derived from the next state.
    always_comb begin
        an_d         = '0;
        seg_d        = 7'd0;
        frame_done_d = (state_d == GAP) && (idx_d == IW'(DIGITS - 1)) &&
                       (cnt_d == CW'(BLANK - 1));
        if (state_d == DRIVE) begin
            an_d[idx_d] = 1'b1;
            seg_d       = dec_s;
        end else begin
            an_d  = '0;
            seg_d = 7'd0;
        end
    end

    // State and output registers; reset blanks the display immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            active_q     <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            en_q         <= 1'b0;
            seg_q        <= 7'd0;
            an_q         <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            active_q     <= active_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            en_q         <= en;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign wr_ready   = !pending_q;
    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_d7s_scan_ctrl.sv
// Self-checking bench for d7s_scan_ctrl with a frame-position reference model.
module tb_d7s_scan_ctrl;

    localparam int DIGITS = 4;
    localparam int DWELL  = 4;
    localparam int BLANK  = 1;
    localparam int SLOT   = DWELL + BLANK;
    localparam int PERIOD = DIGITS * SLOT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        wr_valid;
    logic [15:0] wr_data;
    logic        wr_ready;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_no  = 0;
    int last_fd = -1;

    // Reference model: scanning flag plus position inside the frame.
    bit          m_run;
    bit          m_en_prev;
    bit          m_pending;
    int          m_pos;
    logic [15:0] m_active;
    logic [15:0] m_shadow;

    d7s_scan_ctrl #(.DIGITS(DIGITS), .DWELL(DWELL), .BLANK(BLANK)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_no);
        end
    endtask

    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0111111;
            4'h1: return 7'b0000110;
            4'h2: return 7'b1011011;
            4'h3: return 7'b1001111;
            4'h4: return 7'b1100110;
            4'h5: return 7'b1101101;
            4'h6: return 7'b1111101;
            4'h7: return 7'b0000111;
            4'h8: return 7'b1111111;
            4'h9: return 7'b1101111;
            4'hA: return 7'b1110111;
            4'hB: return 7'b1111100;
            4'hC: return 7'b0111001;
            4'hD: return 7'b1011110;
            4'hE: return 7'b1111001;
            default: return 7'b1110001;
        endcase
    endfunction

    task automatic model_reset();
        m_run     = 1'b0;
        m_en_prev = 1'b0;
        m_pending = 1'b0;
        m_pos     = 0;
        m_active  = 16'h0000;
        m_shadow  = 16'h0000;
        last_fd   = -1;
    endtask

    task automatic model_step(input bit e, input bit wv, input logic [15:0] wd);
        bit acc;
        acc = wv && !m_pending;
        if (!m_run) begin
            if (m_pending) begin
                m_active  = m_shadow;
                m_pending = 1'b0;
            end
            if (e && m_en_prev) begin
                m_run = 1'b1;
                m_pos = 0;
            end
        end else if (!e) begin
            m_run = 1'b0;
        end else begin
            if (m_pos == PERIOD - 1 && m_pending) begin
                m_active  = m_shadow;
                m_pending = 1'b0;
            end
            m_pos = (m_pos + 1) % PERIOD;
        end
        if (acc) begin
            m_shadow  = wd;
            m_pending = 1'b1;
        end
        m_en_prev = e;
    endtask

    // One clock: drive inputs, step the model on the edge, compare just after.
    task automatic cyc(input bit e, input bit wv, input logic [15:0] wd);
        logic [3:0]  exp_an;
        logic [6:0]  exp_seg;
        logic [15:0] act;
        bit          exp_fd;
        int          d;
        en       = e;
        wr_valid = wv;
        wr_data  = wd;
        @(posedge clk);
        model_step(e, wv, wd);
        cyc_no++;
        #1;
        exp_an  = 4'd0;
        exp_seg = 7'd0;
        if (m_run && (m_pos % SLOT) < DWELL) begin
            d       = m_pos / SLOT;
            act     = m_active;
            exp_an  = 4'(1 << d);
            exp_seg = ref_seg(act[d*4 +: 4]);
        end
        exp_fd = m_run && (m_pos == PERIOD - 1);
        check("an", 32'(an), 32'(exp_an));
        check("seg", 32'(seg), 32'(exp_seg));
        check("frame_done", 32'(frame_done), 32'(exp_fd));
        check("wr_ready", 32'(wr_ready), 32'(!m_pending));
        if (!e) last_fd = -1;
        if (frame_done === 1'b1) begin
            if (last_fd >= 0) check("fd_period", 32'(cyc_no - last_fd), 32'(PERIOD));
            last_fd = cyc_no;
        end
    endtask

    task automatic wait_fd(input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 3 * PERIOD && !found; i++) begin
            cyc(1'b1, 1'b0, 16'h0000);
            if (frame_done === 1'b1) found = 1'b1;
        end
        if (!found) check(tag, 32'd0, 32'd1);
    endtask

    initial begin
        bit found;
        rst_n    = 1'b0;
        en       = 1'b0;
        wr_valid = 1'b0;
        wr_data  = 16'h0000;
        model_reset();
        #7;
        check("rst_seg", 32'(seg), 32'd0);
        check("rst_an", 32'(an), 32'd0);
        check("rst_fd", 32'(frame_done), 32'd0);
        check("rst_ready", 32'(wr_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle write, then enable: digit 0 shows 4 after two en-high edges.
        cyc(1'b0, 1'b1, 16'h1234);
        check("idle_wr_ready_low", 32'(wr_ready), 32'd0);
        cyc(1'b0, 1'b0, 16'h0000);
        cyc(1'b0, 1'b0, 16'h0000);
        cyc(1'b1, 1'b0, 16'h0000);
        check("no_drive_first_edge", 32'(an), 32'd0);
        cyc(1'b1, 1'b0, 16'h0000);
        check("first_an", 32'(an), 32'b0001);
        check("first_seg", 32'(seg), 32'b1100110);
        for (int i = 0; i < 45; i++) cyc(1'b1, 1'b0, 16'h0000);

        // Mid-frame write, then a second offer while pending is ignored.
        cyc(1'b1, 1'b1, 16'hABCD);
        check("ready_low_after_wr", 32'(wr_ready), 32'd0);
        cyc(1'b1, 1'b1, 16'h5555);
        wait_fd("wait_fd_abcd_timeout");
        cyc(1'b1, 1'b0, 16'h0000);
        check("abcd_digit0", 32'(seg), 32'b1011110);
        check("ready_after_boundary", 32'(wr_ready), 32'd1);

        // Write offered exactly on the boundary clock.
        wait_fd("wait_fd_boundary_timeout");
        cyc(1'b1, 1'b1, 16'h9876);
        check("late_wr_pending", 32'(wr_ready), 32'd0);
        check("late_wr_not_yet", 32'(seg), 32'b1011110);
        wait_fd("wait_fd_late_timeout");
        cyc(1'b1, 1'b0, 16'h0000);
        check("late_wr_shown", 32'(seg), 32'b1111101);

        // Drop en during the gap after digit 2.
        found = 1'b0;
        for (int i = 0; i < 2 * PERIOD && !found; i++) begin
            if (m_run && m_pos == 2 * SLOT + DWELL) found = 1'b1;
            else cyc(1'b1, 1'b0, 16'h0000);
        end
        if (!found) check("gap2_timeout", 32'd0, 32'd1);
        cyc(1'b0, 1'b0, 16'h0000);
        check("drop_an", 32'(an), 32'd0);
        check("drop_fd", 32'(frame_done), 32'd0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 16'h0000);
        cyc(1'b1, 1'b0, 16'h0000);
        cyc(1'b1, 1'b0, 16'h0000);
        check("restart_digit0", 32'(an), 32'b0001);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 19) != 0), ($urandom_range(0, 5) == 0), 16'($urandom));
        end

        // Reset mid-DRIVE with a write pending.
        cyc(1'b1, 1'b0, 16'h0000);
        cyc(1'b1, 1'b0, 16'h0000);
        found = 1'b0;
        for (int i = 0; i < 2 * PERIOD && !found; i++) begin
            cyc(1'b1, !m_pending, 16'hFEDC);
            if (an !== 4'd0 && !m_pending && m_pos % SLOT < DWELL - 1) found = 1'b1;
        end
        cyc(1'b1, 1'b1, 16'hFEDC);
        if (!found || an === 4'd0) check("mid_drive_timeout", 32'd0, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_seg", 32'(seg), 32'd0);
        check("async_rst_an", 32'(an), 32'd0);
        check("async_rst_ready", 32'(wr_ready), 32'd1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 1'b0, 16'h0000);
        check("post_rst_wait", 32'(an), 32'd0);
        cyc(1'b1, 1'b0, 16'h0000);
        check("post_rst_an", 32'(an), 32'b0001);
        check("post_rst_seg", 32'(seg), 32'b0111111);
        for (int i = 0; i < 25; i++) cyc(1'b1, 1'b0, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
